// File: rtl/datapath_exec_if.sv
// datapath_exec_if -- operand/opcode bus for datapath_exec.
//
// Carries the per-cycle control word (tx, ty, tz, tula), the external
// operand (entrada) and every observable result of the datapath.
//   master : drives opcodes and entrada, observes results (controller / bench)
//   slave  : the datapath itself
// Signals:
//   tx, ty, tz [4:0]   register X/Y/Z opcodes
//   tula [4:0]         ALU operation select
//   entrada [WIDTH]    external operand loaded into X
//   rx, ry, rz [WIDTH] register contents
//   ula [WIDTH]        combinational ALU result
//   flag_zero          last ALU result loaded into Y was zero
//   flag_carry         carry/borrow of last ALU result loaded into Y
//   erro               sticky invalid-opcode indicator
interface datapath_exec_if #(
    parameter int WIDTH = 8
);
    logic [4:0]       tx;
    logic [4:0]       ty;
    logic [4:0]       tz;
    logic [4:0]       tula;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic [WIDTH-1:0] rz;
    logic [WIDTH-1:0] ula;
    logic             flag_zero;
    logic             flag_carry;
    logic             erro;

    modport master (
        output tx, ty, tz, tula, entrada,
        input  rx, ry, rz, ula, flag_zero, flag_carry, erro
    );

    modport slave (
        input  tx, ty, tz, tula, entrada,
        output rx, ry, rz, ula, flag_zero, flag_carry, erro
    );
endinterface

// File: rtl/datapath_exec.sv
// datapath_exec -- three-register datapath (X, Y, Z) around a small ALU.
//
// Every rising clock edge each register applies its own opcode
// (CLEAR / LOAD / HOLD / SHIFTL, plus SHIFTR when enabled). Load sources:
// X <- entrada, Y <- ALU result, Z <- Y. All sources are sampled from the
// pre-edge register values. The ALU is purely combinational on (rx, ry, tula).
// Zero/carry flags track the ALU result only on edges where Y loads it.
// Undefined register opcodes act as HOLD and set the sticky erro bit; an
// undefined ALU code only sets erro when Y actually consumes the result.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high; clears all registers, flags and erro
//   bus    datapath_exec_if.slave (opcodes, entrada, results)
//
// Configuration macro: DATAPATH_EXEC_SHIFTR_EN
//   defined   -> register opcode 4 is SHIFTR (logical right shift by one)
//   undefined -> register opcode 4 is invalid (HOLD + erro)
module datapath_exec #(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    datapath_exec_if.slave    bus
);
    localparam logic [4:0] OP_CLEAR  = 5'd0;
    localparam logic [4:0] OP_LOAD   = 5'd1;
    localparam logic [4:0] OP_HOLD   = 5'd2;
    localparam logic [4:0] OP_SHIFTL = 5'd3;
`ifdef DATAPATH_EXEC_SHIFTR_EN
    localparam logic [4:0] OP_SHIFTR = 5'd4;
`endif

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_PASS = 5'd5;

    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] ry_q, ry_d;
    logic [WIDTH-1:0] rz_q, rz_d;
    logic             flag_zero_q, flag_zero_d;
    logic             flag_carry_q, flag_carry_d;
    logic             erro_q, erro_d;

    logic [WIDTH-1:0] ula_res;
    logic             ula_carry;
    logic             ula_bad;
    logic [WIDTH:0]   sum_ext;
    logic             bad_x, bad_y, bad_z;

    // Shared per-register opcode decode; bad flags an undefined opcode,
    // in which case the register keeps its value.
    function automatic logic [WIDTH-1:0] reg_next(
        input  logic [4:0]       op,
        input  logic [WIDTH-1:0] cur,
        input  logic [WIDTH-1:0] src,
        output logic             bad
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        bad = 1'b0;
        case (op)
            OP_CLEAR:  nxt = '0;
            OP_LOAD:   nxt = src;
            OP_HOLD:   nxt = cur;
            OP_SHIFTL: nxt = {cur[WIDTH-2:0], 1'b0};
`ifdef DATAPATH_EXEC_SHIFTR_EN
            OP_SHIFTR: nxt = {1'b0, cur[WIDTH-1:1]};
`endif
            default:   bad = 1'b1;
        endcase
        return nxt;
    endfunction

    // ALU: operands are always the current register outputs.
    always_comb begin
        sum_ext   = {1'b0, ry_q} + {1'b0, rx_q};
        ula_res   = '0;
        ula_carry = 1'b0;
        ula_bad   = 1'b0;
        case (bus.tula)
            ALU_ADD: begin
                ula_res   = sum_ext[WIDTH-1:0];
                ula_carry = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                ula_res   = ry_q - rx_q;
                ula_carry = (ry_q < rx_q);
            end
            ALU_AND:  ula_res = ry_q & rx_q;
            ALU_OR:   ula_res = ry_q | rx_q;
            ALU_XOR:  ula_res = ry_q ^ rx_q;
            ALU_PASS: ula_res = rx_q;
            default:  ula_bad = 1'b1;
        endcase
    end

    always_comb begin
        rx_d = reg_next(bus.tx, rx_q, bus.entrada, bad_x);
        ry_d = reg_next(bus.ty, ry_q, ula_res, bad_y);
        rz_d = reg_next(bus.tz, rz_q, ry_q, bad_z);

        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        if (bus.ty == OP_LOAD) begin
            flag_zero_d  = (ula_res == '0);
            flag_carry_d = ula_carry;
        end

        // An undefined ALU code only matters when Y consumes the result.
        erro_d = erro_q | bad_x | bad_y | bad_z
               | (ula_bad & (bus.ty == OP_LOAD));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_q         <= '0;
            ry_q         <= '0;
            rz_q         <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            rx_q         <= rx_d;
            ry_q         <= ry_d;
            rz_q         <= rz_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            erro_q       <= erro_d;
        end
    end

    assign bus.rx         = rx_q;
    assign bus.ry         = ry_q;
    assign bus.rz         = rz_q;
    assign bus.ula        = ula_res;
    assign bus.flag_zero  = flag_zero_q;
    assign bus.flag_carry = flag_carry_q;
    assign bus.erro       = erro_q;
endmodule

// File: tb/tb_datapath_exec.sv
module tb_datapath_exec;
    logic clock = 1'b0;
    logic reset = 1'b1;

    datapath_exec_if #(.WIDTH(8)) bus ();

    datapath_exec #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference state, advanced one transaction at a time.
    logic [7:0] m_rx = 8'h00, m_ry = 8'h00, m_rz = 8'h00;
    bit         m_fz = 1'b0, m_fc = 1'b0, m_err = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU reference in plain integer arithmetic.
    task automatic alu_model(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y,
                             output logic [7:0] r, output bit c, output bit bad);
        int s;
        r = 8'h00; c = 1'b0; bad = 1'b0;
        case (op)
            5'd0: begin s = int'(y) + int'(x); r = s[7:0]; c = (s > 255); end
            5'd1: begin s = int'(y) - int'(x) + 256; r = s[7:0]; c = (int'(y) < int'(x)); end
            5'd2: r = y & x;
            5'd3: r = y | x;
            5'd4: r = y ^ x;
            5'd5: r = x;
            default: bad = 1'b1;
        endcase
    endtask

    function automatic logic [7:0] reg_model(input logic [4:0] op, input logic [7:0] cur,
                                             input logic [7:0] ld, output bit bad);
        int v;
        bad = 1'b0;
        v = int'(cur);
        case (op)
            5'd0: v = 0;
            5'd1: v = int'(ld);
            5'd2: v = int'(cur);
            5'd3: v = (int'(cur) * 2) % 256;
`ifdef DATAPATH_EXEC_SHIFTR_EN
            5'd4: v = int'(cur) / 2;
`endif
            default: bad = 1'b1;
        endcase
        return v[7:0];
    endfunction

    // One transaction: present the control word, let one edge happen,
    // advance the model.
    task automatic cycle(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                         input logic [4:0] u, input logic [7:0] e);
        logic [7:0] r, nx, ny, nz;
        bit c, abad, b0, b1, b2;
        bus.tx = x; bus.ty = y; bus.tz = z; bus.tula = u; bus.entrada = e;
        alu_model(u, m_rx, m_ry, r, c, abad);
        nx = reg_model(x, m_rx, e, b0);
        ny = reg_model(y, m_ry, r, b1);
        nz = reg_model(z, m_rz, m_ry, b2);
        @(posedge clock);
        #1;
        m_rx = nx; m_ry = ny; m_rz = nz;
        if (y == 5'd1) begin m_fz = (r == 8'h00); m_fc = c; end
        m_err = m_err | b0 | b1 | b2 | (abad && y == 5'd1);
        $display("txn tx=%0d ty=%0d tz=%0d tula=%0d ent=%02h -> rx=%02h ry=%02h rz=%02h z=%0b c=%0b e=%0b",
                 x, y, z, u, e, bus.rx, bus.ry, bus.rz, bus.flag_zero, bus.flag_carry, bus.erro);
    endtask

    // Asynchronous reset: outputs must clear before any edge; opcodes
    // presented during reset must be ignored.
    task automatic do_reset();
        cmp_en = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_rx", bus.rx, 8'h00);
        chk("rst_ry", bus.ry, 8'h00);
        chk("rst_rz", bus.rz, 8'h00);
        chk("rst_fz", {7'd0, bus.flag_zero}, 8'h00);
        chk("rst_fc", {7'd0, bus.flag_carry}, 8'h00);
        chk("rst_err", {7'd0, bus.erro}, 8'h00);
        bus.tx = 5'd1; bus.ty = 5'd1; bus.tz = 5'd9; bus.tula = 5'd5; bus.entrada = 8'h55;
        @(posedge clock);
        #1;
        chk("rst_hold_rx", bus.rx, 8'h00);
        chk("rst_hold_err", {7'd0, bus.erro}, 8'h00);
        @(negedge clock);
        #1;
        reset = 1'b0;
        m_rx = 8'h00; m_ry = 8'h00; m_rz = 8'h00;
        m_fz = 1'b0; m_fc = 1'b0; m_err = 1'b0;
        cmp_en = 1'b1;
        $display("txn reset done");
    endtask

    // Every-cycle compare against the model.
    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            logic [7:0] er;
            bit ec, eb;
            alu_model(bus.tula, m_rx, m_ry, er, ec, eb);
            chk("cyc_rx", bus.rx, m_rx);
            chk("cyc_ry", bus.ry, m_ry);
            chk("cyc_rz", bus.rz, m_rz);
            chk("cyc_ula", bus.ula, er);
            chk("cyc_fz", {7'd0, bus.flag_zero}, {7'd0, m_fz});
            chk("cyc_fc", {7'd0, bus.flag_carry}, {7'd0, m_fc});
            chk("cyc_err", {7'd0, bus.erro}, {7'd0, m_err});
        end
    end

    function automatic logic [4:0] rnd_op();
        if ($urandom_range(0, 19) == 0) return 5'($urandom_range(4, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx = 5'd2; bus.ty = 5'd2; bus.tz = 5'd2; bus.tula = 5'd0; bus.entrada = 8'h00;
        #1;
        chk("init_rx", bus.rx, 8'h00);
        chk("init_err", {7'd0, bus.erro}, 8'h00);
        do_reset();

        // Load X only.
        cycle(5'd1, 5'd0, 5'd0, 5'd0, 8'h05);
        chk("t1_rx", bus.rx, 8'h05);
        chk("t1_ry", bus.ry, 8'h00);
        chk("t1_rz", bus.rz, 8'h00);
        chk("t1_err", {7'd0, bus.erro}, 8'h00);

        // X and Y load together: Y sees old X + old Y.
        cycle(5'd1, 5'd1, 5'd2, 5'd0, 8'h03);
        chk("t2_rx", bus.rx, 8'h03);
        chk("t2_ry", bus.ry, 8'h05);
        chk("t2_fz", {7'd0, bus.flag_zero}, 8'h00);
        chk("t2_fc", {7'd0, bus.flag_carry}, 8'h00);

        // 0xFF + 0x01 wraps to zero with carry.
        cycle(5'd1, 5'd2, 5'd2, 5'd0, 8'hFF);
        cycle(5'd1, 5'd1, 5'd2, 5'd5, 8'h01);
        chk("t3_ry_ff", bus.ry, 8'hFF);
        cycle(5'd2, 5'd1, 5'd2, 5'd0, 8'h00);
        chk("t3_ry", bus.ry, 8'h00);
        chk("t3_fz", {7'd0, bus.flag_zero}, 8'h01);
        chk("t3_fc", {7'd0, bus.flag_carry}, 8'h01);

        // 0x82 + 0xFF = 0x181 -> ry=0x81, carry; then shift left keeps flags.
        cycle(5'd1, 5'd2, 5'd2, 5'd0, 8'h82);
        cycle(5'd1, 5'd1, 5'd2, 5'd5, 8'hFF);
        cycle(5'd2, 5'd1, 5'd2, 5'd0, 8'h00);
        chk("t3_ry81", bus.ry, 8'h81);
        cycle(5'd2, 5'd3, 5'd2, 5'd7, 8'h00);
        chk("t3_shl", bus.ry, 8'h02);
        chk("t3_fz_hold", {7'd0, bus.flag_zero}, 8'h00);
        chk("t3_fc_hold", {7'd0, bus.flag_carry}, 8'h01);
        chk("t3_err_alu_unused", {7'd0, bus.erro}, 8'h00);

        // Z loads from Y; then clear.
        cycle(5'd1, 5'd2, 5'd2, 5'd0, 8'h12);
        cycle(5'd2, 5'd1, 5'd2, 5'd5, 8'h00);
        cycle(5'd2, 5'd2, 5'd1, 5'd0, 8'h00);
        chk("t4_rz", bus.rz, 8'h12);
        chk("t4_ry", bus.ry, 8'h12);
        cycle(5'd2, 5'd2, 5'd0, 5'd0, 8'h00);
        chk("t4_rz_clr", bus.rz, 8'h00);

        // Subtract: equal operands, then borrow.
        cycle(5'd2, 5'd1, 5'd2, 5'd1, 8'h00);
        chk("t5_sub0", bus.ry, 8'h00);
        chk("t5_fz", {7'd0, bus.flag_zero}, 8'h01);
        cycle(5'd2, 5'd1, 5'd2, 5'd1, 8'h00);
        chk("t5_borrow", bus.ry, 8'hEE);
        chk("t5_fc", {7'd0, bus.flag_carry}, 8'h01);

        // Opcode 4 on X.
        cycle(5'd1, 5'd2, 5'd2, 5'd0, 8'h80);
        cycle(5'd4, 5'd2, 5'd2, 5'd0, 8'h00);
`ifdef DATAPATH_EXEC_SHIFTR_EN
        chk("t6_shr", bus.rx, 8'h40);
        chk("t6_err", {7'd0, bus.erro}, 8'h00);
        // Undefined ALU code consumed by Y: result 0, erro set.
        cycle(5'd2, 5'd1, 5'd2, 5'd6, 8'h00);
        chk("t6_alu_bad_ry", bus.ry, 8'h00);
        chk("t6_alu_bad_err", {7'd0, bus.erro}, 8'h01);
`else
        chk("t6_hold", bus.rx, 8'h80);
        chk("t6_err", {7'd0, bus.erro}, 8'h01);
`endif
        cycle(5'd1, 5'd1, 5'd1, 5'd0, 8'h11);
        chk("t6_err_sticky", {7'd0, bus.erro}, 8'h01);

        // Build rx=ry=rz=0xAA with erro set, then reset between edges.
        cycle(5'd1, 5'd2, 5'd2, 5'd0, 8'hAA);
        cycle(5'd2, 5'd1, 5'd2, 5'd5, 8'h00);
        cycle(5'd7, 5'd2, 5'd1, 5'd0, 8'h00);
        chk("t7_rx", bus.rx, 8'hAA);
        chk("t7_rz", bus.rz, 8'hAA);
        chk("t7_err", {7'd0, bus.erro}, 8'h01);
        do_reset();

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            cycle(rnd_op(), rnd_op(), rnd_op(), 5'($urandom_range(0, 7)), 8'($urandom));
        end

        cmp_en = 1'b0;
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
